sequence_engine: RTL and testbench



---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_store.sv | 37 +++
 rtl/sequence_engine.sv | 211 +++++++++++++++++++++
 tb/tb_sequence_engine.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and helpers for the memory-game sequence engine
//
// Contents:
//   SYM_W   : width of one colour symbol
//   sym_t   : one colour symbol
//   state_t : sequence_engine FSM states
//   max2    : constant helper used to size the display timer
package seq_pkg;

  localparam int SYM_W = 2;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPEND = 3'd1,
    SHOW   = 3'd2,
    GAP    = 3'd3,
    INPUT  = 3'd4,
    OVER   = 3'd5
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_store.sv
// rtl/seq_store.sv - colour sequence register file, sync write / async read
//
// Ports:
//   i_clk    : clock, write on rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : symbol to store
//   i_raddr  : read address
//   o_rdata  : symbol at i_raddr (combinational read)
//
// No reset: entries are only read below the current sequence length, and
// every such entry has been written during the current game.
module seq_store
  import seq_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [SYM_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [SYM_W-1:0]  o_rdata
);

  sym_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sequence_engine.sv
// rtl/sequence_engine.sv - memory-game sequence append, replay and check core
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   clear       : synchronous game restart, beats every other input
//   round_start : pulse, append rand_sym and replay the whole sequence
//   rand_sym    : random colour to append
//   btn_valid   : pulse, player pressed a button
//   btn_sym     : colour of the pressed button
//   led_valid   : a symbol is being displayed
//   led_sym     : displayed colour, 0 when led_valid is low
//   busy        : in APPEND, SHOW, GAP or INPUT
//   await_input : waiting for the player
//   round_ok    : pulse, round entered correctly
//   fail        : pulse, wrong button
//   win         : level, MAX_LEN rounds completed, held until clear/reset
//   seq_len     : number of stored symbols
//
// Every output comes from a register or from a decode of registered state
// (led_sym reads the store at the registered index), so no input reaches an
// output combinationally.
module sequence_engine
  import seq_pkg::*;
#(
  parameter  int MAX_LEN     = 16,
  parameter  int SHOW_CYCLES = 4,
  parameter  int GAP_CYCLES  = 2,
  localparam int IDX_W       = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             round_start,
  input  logic [SYM_W-1:0] rand_sym,
  input  logic             btn_valid,
  input  logic [SYM_W-1:0] btn_sym,
  output logic             led_valid,
  output logic [SYM_W-1:0] led_sym,
  output logic             busy,
  output logic             await_input,
  output logic             round_ok,
  output logic             fail,
  output logic             win,
  output logic [IDX_W:0]   seq_len
);

  // Timer only ever counts 0 .. max(SHOW_CYCLES, GAP_CYCLES)-1.
  localparam int TMR_W = $clog2(max2(SHOW_CYCLES, GAP_CYCLES) + 1);

  localparam logic [IDX_W:0]   C_MAX_LEN   = (IDX_W+1)'(MAX_LEN);
  localparam logic [IDX_W:0]   C_LEN_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] C_IDX_ONE   = IDX_W'(1);
  localparam logic [TMR_W-1:0] C_TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] C_SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] C_GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

  state_t           r_state;
  logic [IDX_W:0]   r_seq_len;
  logic [IDX_W-1:0] r_idx;
  logic [TMR_W-1:0] r_timer;
  logic             r_round_ok;
  logic             r_fail;
  logic             r_win;

  state_t           w_state_nxt;
  logic [IDX_W:0]   w_seq_len_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             w_round_ok_nxt;
  logic             w_fail_nxt;
  logic             w_win_nxt;

  logic             w_we;
  logic [SYM_W-1:0] w_rdata;
  logic             w_idx_last;
  logic             w_not_full;

  seq_store #(
    .DEPTH (MAX_LEN)
  ) u_store (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_seq_len[IDX_W-1:0]),
    .i_wdata (rand_sym),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  // idx + 1 == seq_len, written this way so seq_len = 0 cannot underflow.
  assign w_idx_last = (({1'b0, r_idx} + C_LEN_ONE) == r_seq_len);
  assign w_not_full = (r_seq_len < C_MAX_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_seq_len  <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_round_ok <= 1'b0;
      r_fail     <= 1'b0;
      r_win      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_seq_len  <= w_seq_len_nxt;
      r_idx      <= w_idx_nxt;
      r_timer    <= w_timer_nxt;
      r_round_ok <= w_round_ok_nxt;
      r_fail     <= w_fail_nxt;
      r_win      <= w_win_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_seq_len_nxt  = r_seq_len;
    w_idx_nxt      = r_idx;
    w_timer_nxt    = r_timer;
    w_round_ok_nxt = 1'b0;
    w_fail_nxt     = 1'b0;
    w_win_nxt      = r_win;
    w_we           = 1'b0;

    if (clear) begin
      w_state_nxt   = IDLE;
      w_seq_len_nxt = '0;
      w_idx_nxt     = '0;
      w_timer_nxt   = '0;
      w_win_nxt     = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (round_start && w_not_full) begin
            w_we          = 1'b1;
            w_seq_len_nxt = r_seq_len + C_LEN_ONE;
            w_state_nxt   = APPEND;
          end
        end

        APPEND: begin
          w_idx_nxt   = '0;
          w_timer_nxt = '0;
          w_state_nxt = SHOW;
        end

        SHOW: begin
          if (r_timer == C_SHOW_LAST) begin
            w_timer_nxt = '0;
            w_state_nxt = GAP;
          end else begin
            w_timer_nxt = r_timer + C_TMR_ONE;
          end
        end

        GAP: begin
          if (r_timer == C_GAP_LAST) begin
            w_timer_nxt = '0;
            if (w_idx_last) begin
              w_idx_nxt   = '0;
              w_state_nxt = INPUT;
            end else begin
              w_idx_nxt   = r_idx + C_IDX_ONE;
              w_state_nxt = SHOW;
            end
          end else begin
            w_timer_nxt = r_timer + C_TMR_ONE;
          end
        end

        INPUT: begin
          if (btn_valid) begin
            if (btn_sym != w_rdata) begin
              w_fail_nxt  = 1'b1;
              w_state_nxt = OVER;
            end else if (w_idx_last) begin
              w_round_ok_nxt = 1'b1;
              w_idx_nxt      = '0;
              if (r_seq_len == C_MAX_LEN) begin
                w_win_nxt   = 1'b1;
                w_state_nxt = OVER;
              end else begin
                w_state_nxt = IDLE;
              end
            end else begin
              w_idx_nxt = r_idx + C_IDX_ONE;
            end
          end
        end

        OVER: begin
          // Parked until clear or reset; win keeps its value.
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign led_valid   = (r_state == SHOW);
  assign led_sym     = led_valid ? w_rdata : '0;
  assign busy        = (r_state == APPEND) || (r_state == SHOW) ||
                       (r_state == GAP)    || (r_state == INPUT);
  assign await_input = (r_state == INPUT);
  assign round_ok    = r_round_ok;
  assign fail        = r_fail;
  assign win         = r_win;
  assign seq_len     = r_seq_len;

endmodule

// File: tb/tb_sequence_engine.sv
// tb/tb_sequence_engine.sv - scoreboard bench for sequence_engine
module tb_sequence_engine;

  localparam int MAX_LEN = 4;
  localparam int SHOW    = 4;
  localparam int GAP     = 2;

  typedef enum int {EV_LED, EV_OK, EV_BAD} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [1:0] sym;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       round_start;
  logic [1:0] rand_sym;
  logic       btn_valid;
  logic [1:0] btn_sym;
  logic       led_valid;
  logic [1:0] led_sym;
  logic       busy;
  logic       await_input;
  logic       round_ok;
  logic       fail;
  logic       win;
  logic [2:0] seq_len;

  int         n_vec = 0;
  int         n_err = 0;
  ev_t        exp_q[$];
  logic [1:0] model_seq[$];
  logic [1:0] win_syms[4] = '{2'b11, 2'b00, 2'b10, 2'b01};

  sequence_engine #(
    .MAX_LEN     (MAX_LEN),
    .SHOW_CYCLES (SHOW),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .round_start (round_start),
    .rand_sym    (rand_sym),
    .btn_valid   (btn_valid),
    .btn_sym     (btn_sym),
    .led_valid   (led_valid),
    .led_sym     (led_sym),
    .busy        (busy),
    .await_input (await_input),
    .round_ok    (round_ok),
    .fail        (fail),
    .win         (win),
    .seq_len     (seq_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [1:0] s);
    ev_t e;
    e.kind = k;
    e.sym  = s;
    exp_q.push_back(e);
  endtask

  task automatic see_ev(input ev_kind_t k, input logic [1:0] s, output logic [1:0] exp_sym);
    ev_t e;
    n_vec++;
    exp_sym = s;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d sym %0d, expected nothing", k, s);
    end else begin
      e = exp_q.pop_front();
      exp_sym = e.sym;
      if (e.kind != k || (k == EV_LED && e.sym != s)) begin
        n_err++;
        $display("FAIL event_order: got kind %0d sym %0d, expected kind %0d sym %0d",
                 k, s, e.kind, e.sym);
      end
    end
  endtask

  // Monitor: pops the scoreboard on each displayed symbol and each pulse.
  bit         prev_led = 1'b0;
  int         run = 0;
  logic [1:0] cur_sym = 2'b00;
  logic [1:0] dummy;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_led = 1'b0;
      run      = 0;
    end else begin
      if (led_valid && !prev_led) begin
        see_ev(EV_LED, led_sym, cur_sym);
        run = 0;
      end
      if (led_valid) begin
        run++;
        chk("led_sym_hold", led_sym, cur_sym);
      end else begin
        chk("led_sym_blank", led_sym, 0);
      end
      if (!led_valid && prev_led) chk("show_cycles", run, SHOW);
      if (round_ok) see_ev(EV_OK, 2'b00, dummy);
      if (fail) see_ev(EV_BAD, 2'b00, dummy);
      prev_led = led_valid;
    end
  end

  task automatic wait_input();
    int n = 0;
    while (!await_input && n < 100) begin
      tick();
      n++;
    end
    chk("await_input_reached", await_input, 1);
  endtask

  task automatic start_round(input logic [1:0] sym);
    model_seq.push_back(sym);
    foreach (model_seq[i]) push_ev(EV_LED, model_seq[i]);
    round_start = 1'b1;
    rand_sym    = sym;
    tick();
    round_start = 1'b0;
    rand_sym    = 2'b00;
    chk("seq_len_after_start", seq_len, model_seq.size());
  endtask

  task automatic press_all();
    for (int i = 0; i < model_seq.size(); i++) begin
      if (i == model_seq.size() - 1) push_ev(EV_OK, 2'b00);
      btn_valid = 1'b1;
      btn_sym   = model_seq[i];
      tick();
      btn_valid = 1'b0;
      btn_sym   = 2'b00;
    end
    chk("round_ok_pulse", round_ok, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_led_valid"}, led_valid, 0);
    chk({tag, "_led_sym"}, led_sym, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_await"}, await_input, 0);
    chk({tag, "_round_ok"}, round_ok, 0);
    chk({tag, "_fail_pulse"}, fail, 0);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_seq_len"}, seq_len, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    round_start = 1'b0;
    rand_sym    = 2'b00;
    btn_valid   = 1'b0;
    btn_sym     = 2'b00;

    // Reset state before any clock edge.
    #3;
    chk_all_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // One symbol: latency of append, show, gap, input.
    model_seq.push_back(2'b10);
    push_ev(EV_LED, 2'b10);
    round_start = 1'b1;
    rand_sym    = 2'b10;
    tick();
    round_start = 1'b0;
    rand_sym    = 2'b00;
    chk("append_seq_len", seq_len, 1);
    chk("append_busy", busy, 1);
    chk("append_led", led_valid, 0);
    tick();
    chk("show_first_led", led_valid, 1);
    chk("show_first_sym", led_sym, 2);
    repeat (3) tick();
    chk("show_last_led", led_valid, 1);
    tick();
    chk("gap1_led", led_valid, 0);
    chk("gap1_await", await_input, 0);
    tick();
    chk("gap2_led", led_valid, 0);
    tick();
    chk("input_latency", await_input, 1);
    press_all();
    chk("round1_back_idle", busy, 0);

    // Second round replays 10 then 01.
    start_round(2'b01);
    wait_input();
    press_all();
    chk("round2_back_idle", busy, 0);

    // Button during SHOW is ignored: no fail, index unchanged.
    start_round(2'b11);
    tick();
    chk("ignore_in_show_led", led_valid, 1);
    btn_valid = 1'b1;
    btn_sym   = 2'b00;
    tick();
    btn_valid = 1'b0;
    wait_input();
    press_all();
    chk("round3_seq_len", seq_len, 3);

    // Wrong input after two-symbol playback.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_seq.delete();
    chk("clear_seq_len", seq_len, 0);
    start_round(2'b10);
    wait_input();
    press_all();
    start_round(2'b01);
    wait_input();
    btn_valid = 1'b1;
    btn_sym   = 2'b10;
    tick();
    btn_sym   = 2'b11;
    push_ev(EV_BAD, 2'b00);
    tick();
    btn_valid = 1'b0;
    btn_sym   = 2'b00;
    chk("wrong_fail_pulse", fail, 1);
    chk("wrong_await", await_input, 0);
    chk("wrong_busy", busy, 0);
    tick();
    chk("fail_single_pulse", fail, 0);
    round_start = 1'b1;
    rand_sym    = 2'b00;
    tick();
    round_start = 1'b0;
    chk("over_ignores_start", seq_len, 2);
    repeat (3) tick();
    chk("over_not_busy", busy, 0);
    btn_valid = 1'b1;
    btn_sym   = 2'b01;
    tick();
    btn_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_seq.delete();
    chk("over_clear_seq_len", seq_len, 0);
    chk("over_clear_busy", busy, 0);

    // clear beats a simultaneous round_start.
    clear       = 1'b1;
    round_start = 1'b1;
    rand_sym    = 2'b11;
    tick();
    clear       = 1'b0;
    round_start = 1'b0;
    rand_sym    = 2'b00;
    chk("clear_prio_seq_len", seq_len, 0);
    chk("clear_prio_busy", busy, 0);
    repeat (10) tick();
    chk("clear_prio_still_idle", busy, 0);

    // Win after MAX_LEN correct rounds.
    for (int r = 0; r < 4; r++) begin
      start_round(win_syms[r]);
      wait_input();
      press_all();
      chk("win_level", win, (r == 3) ? 1 : 0);
    end
    repeat (5) tick();
    chk("win_held", win, 1);
    round_start = 1'b1;
    rand_sym    = 2'b10;
    tick();
    round_start = 1'b0;
    chk("full_start_ignored", seq_len, 4);
    chk("full_not_busy", busy, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_seq.delete();
    chk("win_cleared", win, 0);
    chk("win_clear_seq_len", seq_len, 0);

    // Reset mid-SHOW drops every output without a clock edge.
    model_seq.push_back(2'b01);
    push_ev(EV_LED, 2'b01);
    round_start = 1'b1;
    rand_sym    = 2'b01;
    tick();
    round_start = 1'b0;
    rand_sym    = 2'b00;
    tick();
    chk("pre_reset_led", led_valid, 1);
    #5;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midshow_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    model_seq.delete();
    tick();
    chk("post_reset_seq_len", seq_len, 0);
    chk("post_reset_busy", busy, 0);

    repeat (5) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events: got %0d left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
